odd_even: RTL and testbench

// - Switch-bank parity indicator for the Boolean board: samples the 8 slide switches,

---
 rtl/odd_even.sv | 104 ++++++++++
 tb/tb_odd_even.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/odd_even.sv
// Switch-bank parity indicator: samples WIDTH switches, counts the ones and lights
// led[0] for an odd count or led[1] for an even count (zero ones is even).
// Build option ODD_EVEN_SYNC_EN: when defined, a two-flop synchroniser sits on sw
// (latency 3); when undefined, sw feeds the parity logic directly (latency 1).
module odd_even #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [1:0]       led
);

`ifdef ODD_EVEN_SYNC_EN
  localparam int unsigned LATENCY = 3;
`else
  localparam int unsigned LATENCY = 1;
`endif
  localparam int unsigned CNTW  = $clog2(LATENCY + 1);
  localparam int unsigned ONESW = $clog2(WIDTH + 1);

  // Sample presented to the parity logic.
  logic [WIDTH-1:0] samp;

`ifdef ODD_EVEN_SYNC_EN
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // Two-flop synchroniser for the asynchronous switch levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = sw;
`endif

  logic [ONESW-1:0] ones;
  logic             odd;

  // Population count of the sample; its LSB is the parity.
  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones = ones + ONESW'(samp[i]);
    end
  end

  assign odd = ones[0];

  logic [CNTW-1:0] fill_q;
  logic [CNTW-1:0] fill_d;
  logic            fill_done;

  // Fill counter saturates at LATENCY; it counts edges since reset release.
  always_comb begin
    fill_d = fill_q;
    if (fill_q != CNTW'(LATENCY)) begin
      fill_d = fill_q + CNTW'(1);
    end
  end

  // The edge that brings the counter to LATENCY is the first to load a real sample.
  assign fill_done = (fill_d == CNTW'(LATENCY));

  // Fill counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  logic [1:0] led_q;
  logic [1:0] led_d;

  // One-hot parity encoding, blanked until the pipeline is full.
  always_comb begin
    led_d = 2'b00;
    if (fill_done) begin
      led_d = odd ? 2'b01 : 2'b10;
    end
  end

  // Output register driving the LED pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q <= 2'b00;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_odd_even.sv
// Scoreboard bench for odd_even. The driver computes the expected LED value for each
// clock edge from a behavioural model (history of sampled switch values and a count of
// edges since reset) and queues it; the monitor pops one entry after every edge.
module tb_odd_even;

`ifdef ODD_EVEN_SYNC_EN
  localparam int LATENCY = 3;
`else
  localparam int LATENCY = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  logic [1:0] led;

  always #5 clk = ~clk;

  odd_even #(
    .WIDTH(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw),
    .led  (led)
  );

  typedef struct {
    logic [1:0] exp;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Model state: switch values seen on edges since reset, and number of such edges.
  logic [7:0] hist[$];
  int         run_edges = 0;

  function automatic logic [1:0] parity_led(input logic [7:0] v);
    int cnt = 0;
    for (int i = 0; i < 8; i++) cnt += int'(v[i]);
    return (cnt % 2 == 1) ? 2'b01 : 2'b10;
  endfunction

  // Drive one cycle of stimulus and queue the LED value expected after the next edge.
  task automatic step(input logic [7:0] s, input logic r, input string tag);
    exp_t e;
    @(negedge clk);
    sw    = s;
    rst_n = r;
    if (!r) begin
      run_edges = 0;
      hist.delete();
      e.exp = 2'b00;
    end else begin
      if (run_edges < 1000) run_edges++;
      hist.push_back(s);
      if (hist.size() > LATENCY) void'(hist.pop_front());
      e.exp = (run_edges >= LATENCY) ? parity_led(hist[0]) : 2'b00;
    end
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT output after each edge against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (led !== e.exp) begin
          n_fail++;
          $display("FAIL %s: led=%b expected %b at %0t", e.tag, led, e.exp, $time);
        end
        if (e.exp != 2'b00) begin
          n_cmp++;
          if (!$onehot(led)) begin
            n_fail++;
            $display("FAIL onehot_%s: led=%b expected one-hot at %0t", e.tag, led, $time);
          end
        end
      end
    end
  end

  logic [7:0] sweep_vals[8] = '{8'h00, 8'h60, 8'h1C, 8'h55, 8'h5E, 8'h7B, 8'hBF, 8'hFF};

  initial begin
    int waited;
    rst_n = 1'b0;
    sw    = 8'h00;

    // Reset held with all switches on, then release and watch the fill.
    for (int i = 0; i < 4; i++) step(8'hFF, 1'b0, "reset_hold");
    for (int i = 0; i < LATENCY + 3; i++) step(8'hFF, 1'b1, "reset_release");

    // Parity sweep, each value held longer than the latency.
    foreach (sweep_vals[k]) begin
      for (int i = 0; i < LATENCY + 2; i++) step(sweep_vals[k], 1'b1, "sweep");
    end

    // Back-to-back samples.
    step(8'h01, 1'b1, "b2b");
    step(8'h03, 1'b1, "b2b");
    for (int i = 0; i < LATENCY + 2; i++) step(8'h07, 1'b1, "b2b");

    // Mid-run reset pulse.
    for (int i = 0; i < LATENCY + 2; i++) step(8'h1C, 1'b1, "midrst_pre");
    step(8'h1C, 1'b0, "midrst_pulse");
    for (int i = 0; i < LATENCY + 3; i++) step(8'h1C, 1'b1, "midrst_post");

    // Exhaustive sweep, one value per cycle.
    for (int v = 0; v < 256; v++) step(8'(v), 1'b1, "exhaustive");

    // Random values with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      step(8'($urandom), ($urandom_range(0, 24) != 0), "random");
    end
    for (int i = 0; i < LATENCY + 2; i++) step(8'hA5, 1'b1, "tail");

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
